// File: rtl/lcd_pkg.sv
// Shared LCD definitions: dot-matrix geometry, icon nibble addresses, scan FSM states
// and the dot-to-RAM address mapping.
package lcd_pkg;

    localparam int LCD_WIDTH  = 32;
    localparam int LCD_HEIGHT = 16;

    localparam logic [7:0] ICON_ADDR_LO = 8'h80;
    localparam logic [7:0] ICON_ADDR_HI = 8'h81;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ICON0   = 3'd1,
        ICON1   = 3'd2,
        FETCH   = 3'd3,
        PRESENT = 3'd4
    } scan_state_t;

    // Four vertically adjacent dots share one nibble; y[1:0] selects the bit.
    function automatic logic [7:0] dot_address(input logic [4:0] x, input logic [3:0] y);
        return {1'b0, y[3:2], x};
    endfunction

endpackage

// File: rtl/video_ram_scanout.sv
// Frame scanner for the 256x4 LCD video RAM: latches the icon nibbles, then streams the
// 32x16 dot matrix in raster order over a valid/ready pixel interface.
module video_ram_scanout
    import lcd_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_frame,
    output logic [7:0] vram_address,
    input  logic [3:0] vram_q,
    output logic       pixel_valid,
    input  logic       pixel_ready,
    output logic       pixel_on,
    output logic [4:0] pixel_x,
    output logic [3:0] pixel_y,
    output logic       pixel_last,
    output logic [7:0] icons,
    output logic       busy
);

    scan_state_t r_state;
    scan_state_t w_next_state;

    logic       r_wait_arm;
    logic [1:0] r_wait_cnt;
    logic [4:0] r_x;
    logic [3:0] r_y;
    logic [7:0] r_shadow;

    logic [7:0] r_vram_address;
    logic       r_pixel_valid;
    logic       r_pixel_on;
    logic [4:0] r_pixel_x;
    logic [3:0] r_pixel_y;
    logic       r_pixel_last;
    logic [7:0] r_icons;
    logic       r_busy;

    logic       w_data_ok;
    logic       w_accept;
    logic       w_last_pos;
    logic       w_enter_read;
    logic [4:0] w_fetch_x;
    logic [3:0] w_fetch_y;
    logic [7:0] w_next_addr;

    // The first cycle of every read state launches the address; the counter covers the rest.
    assign w_data_ok  = !r_wait_arm && (r_wait_cnt == 2'd0);
    assign w_accept   = (r_state == PRESENT) && pixel_ready;
    assign w_last_pos = (r_x == 5'(LCD_WIDTH - 1)) && (r_y == 4'(LCD_HEIGHT - 1));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start_frame) w_next_state = ICON0; else w_next_state = IDLE;
            ICON0:   if (w_data_ok)   w_next_state = ICON1; else w_next_state = ICON0;
            ICON1:   if (w_data_ok)   w_next_state = FETCH; else w_next_state = ICON1;
            FETCH:   if (w_data_ok)   w_next_state = PRESENT; else w_next_state = FETCH;
            PRESENT: begin
                if (w_accept) begin
                    if (w_last_pos) w_next_state = IDLE; else w_next_state = FETCH;
                end else begin
                    w_next_state = PRESENT;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Read-launch decode: next scan position and the address issued on entering a read state
    always_comb begin
        w_enter_read = 1'b0;
        w_next_addr  = r_vram_address;
        w_fetch_x    = 5'd0;
        w_fetch_y    = 4'd0;
        if (r_state == PRESENT) begin
            w_fetch_x = r_x + 5'd1;
            w_fetch_y = r_y + {3'd0, (r_x == 5'(LCD_WIDTH - 1))};
        end else begin
            w_fetch_x = 5'd0;
            w_fetch_y = 4'd0;
        end
        if (w_next_state != r_state) begin
            case (w_next_state)
                ICON0:   begin w_enter_read = 1'b1; w_next_addr = ICON_ADDR_LO; end
                ICON1:   begin w_enter_read = 1'b1; w_next_addr = ICON_ADDR_HI; end
                FETCH:   begin w_enter_read = 1'b1; w_next_addr = dot_address(w_fetch_x, w_fetch_y); end
                default: w_enter_read = 1'b0;
            endcase
        end else begin
            w_enter_read = 1'b0;
        end
    end

    // Datapath: address, wait counter, scan position, icon shadow and pixel outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wait_arm     <= 1'b0;
            r_wait_cnt     <= 2'd0;
            r_x            <= 5'd0;
            r_y            <= 4'd0;
            r_shadow       <= 8'h00;
            r_vram_address <= 8'h00;
            r_pixel_valid  <= 1'b0;
            r_pixel_on     <= 1'b0;
            r_pixel_x      <= 5'd0;
            r_pixel_y      <= 4'd0;
            r_pixel_last   <= 1'b0;
            r_icons        <= 8'h00;
            r_busy         <= 1'b0;
        end else begin
            r_busy <= (w_next_state != IDLE);
            if (w_enter_read) begin
                r_vram_address <= w_next_addr;
                r_wait_arm     <= 1'b1;
                r_wait_cnt     <= 2'(READ_LATENCY - 1);
            end else if (r_wait_arm) begin
                r_wait_arm <= 1'b0;
            end else if (r_wait_cnt != 2'd0) begin
                r_wait_cnt <= r_wait_cnt - 2'd1;
            end
            if ((r_state == ICON0) && w_data_ok) begin
                r_shadow[3:0] <= vram_q;
            end
            if ((r_state == ICON1) && w_data_ok) begin
                r_shadow[7:4] <= vram_q;
                r_x           <= 5'd0;
                r_y           <= 4'd0;
            end
            if ((r_state == FETCH) && w_data_ok) begin
                r_pixel_valid <= 1'b1;
                r_pixel_on    <= vram_q[r_y[1:0]];
                r_pixel_x     <= r_x;
                r_pixel_y     <= r_y;
                r_pixel_last  <= w_last_pos;
            end
            // Icons are committed only with the final pixel so a frame never shows a torn update.
            if (w_accept) begin
                r_pixel_valid <= 1'b0;
                if (w_last_pos) begin
                    r_icons <= r_shadow;
                end else begin
                    r_x <= w_fetch_x;
                    r_y <= w_fetch_y;
                end
            end
        end
    end

    assign vram_address = r_vram_address;
    assign pixel_valid  = r_pixel_valid;
    assign pixel_on     = r_pixel_on;
    assign pixel_x      = r_pixel_x;
    assign pixel_y      = r_pixel_y;
    assign pixel_last   = r_pixel_last;
    assign icons        = r_icons;
    assign busy         = r_busy;

endmodule
